// File: rtl/clock_pkg.sv
// Shared definitions for the clock/calendar datapath:
// mode encoding, field widths and the month-length table.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_DATE  = 2'd2,
        MODE_SET_ALARM = 2'd3
    } mode_e;

    localparam int HH_W  = 5;
    localparam int MM_W  = 6;
    localparam int SS_W  = 6;
    localparam int DAY_W = 5;
    localparam int MON_W = 4;

    // No leap years: February is always 28 days.
    function automatic logic [DAY_W-1:0] monthLen(input logic [MON_W-1:0] m);
        unique case (m)
            4'd2:                      monthLen = 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   monthLen = 5'd30;
            default:                   monthLen = 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides mclk down to a one-cycle pulse per second.
// hold parks the counter at 0 so a release starts a full period.
module sec_prescaler #(
    parameter int MFREQ_KHZ = 1
) (
    input  logic mclk,
    input  logic rst,
    input  logic hold,
    output logic sec_tick
);

    localparam logic [31:0] LAST = 32'(MFREQ_KHZ * 1000 - 1);

    logic [31:0] count;

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            sec_tick <= 1'b0;
        end else if (hold) begin
            count    <= '0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= (count == LAST);
            count    <= (count == LAST) ? '0 : count + 32'd1;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day, calendar and alarm state with per-mode user edits.
// Button pulses edit date/alarm fields; the second tick only moves time.
module time_keeper
    import clock_pkg::*;
#(
    parameter int MFREQ_KHZ  = 1,
    parameter int ALARM_SECS = 60
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic [1:0]  clk_mode,
    input  logic [1:0]  vButton,
    output logic [4:0]  hh,
    output logic [5:0]  mm,
    output logic [5:0]  ss,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [4:0]  alarm_hh,
    output logic [5:0]  alarm_mm,
    output logic        sec_tick,
    output logic        alarm_active
);

    localparam logic [31:0] ALARM_LAST = 32'(ALARM_SECS - 1);

    mode_e mode;
    logic  setTime;
    assign mode    = mode_e'(clk_mode);
    assign setTime = (mode == MODE_SET_TIME);

    sec_prescaler #(.MFREQ_KHZ(MFREQ_KHZ)) uPrescaler (
        .mclk     (mclk),
        .rst      (rst),
        .hold     (setTime),
        .sec_tick (sec_tick)
    );

    logic [5:0] mmInc, ssTick, mmTick;
    logic [4:0] hhInc, hhTick, curLen;
    logic [3:0] monthInc;
    logic       dayCarry;

    assign mmInc    = (mm == 6'd59) ? '0 : mm + 6'd1;
    assign hhInc    = (hh == 5'd23) ? '0 : hh + 5'd1;
    assign monthInc = (month == 4'd12) ? 4'd1 : month + 4'd1;
    assign curLen   = monthLen(month);

    always_comb begin
        ssTick   = (ss == 6'd59) ? '0 : ss + 6'd1;
        mmTick   = mm;
        hhTick   = hh;
        dayCarry = 1'b0;
        if (ss == 6'd59) begin
            mmTick = mmInc;
            if (mm == 6'd59) begin
                hhTick   = hhInc;
                dayCarry = (hh == 5'd23);
            end
        end
    end

    logic [5:0] mmNext, ssNext, aMmNext;
    logic [4:0] hhNext, dayNext, aHhNext;
    logic [3:0] monthNext;

    always_comb begin
        hhNext    = hh;
        mmNext    = mm;
        ssNext    = ss;
        dayNext   = day;
        monthNext = month;
        aHhNext   = alarm_hh;
        aMmNext   = alarm_mm;
        if (!setTime && sec_tick) begin
            ssNext = ssTick;
            mmNext = mmTick;
            hhNext = hhTick;
        end
        // Date editing mode drops the midnight carry to keep the date still.
        if (sec_tick && dayCarry &&
            (mode == MODE_RUN || mode == MODE_SET_ALARM)) begin
            if (day == curLen) begin
                dayNext   = 5'd1;
                monthNext = monthInc;
            end else begin
                dayNext = day + 5'd1;
            end
        end
        unique case (mode)
            MODE_SET_TIME: begin
                ssNext = '0;
                if (vButton[0]) mmNext = mmInc;
                if (vButton[1]) hhNext = hhInc;
            end
            MODE_SET_DATE: begin
                if (vButton[0]) dayNext = (day == curLen) ? 5'd1 : day + 5'd1;
                if (vButton[1]) begin
                    monthNext = monthInc;
                    if (dayNext > monthLen(monthInc))
                        dayNext = monthLen(monthInc);
                end
            end
            MODE_SET_ALARM: begin
                if (vButton[0]) aMmNext = (alarm_mm == 6'd59) ? '0 : alarm_mm + 6'd1;
                if (vButton[1]) aHhNext = (alarm_hh == 5'd23) ? '0 : alarm_hh + 5'd1;
            end
            default: begin
            end
        endcase
    end

    logic [31:0] alarmCnt;
    logic        alarmHit, alarmClr;

    assign alarmHit = (mode == MODE_RUN) && sec_tick && (ssTick == '0) &&
                      (mmTick == alarm_mm) && (hhTick == alarm_hh);
    assign alarmClr = (|vButton) || (mode != MODE_RUN) ||
                      (alarm_active && sec_tick && alarmCnt == ALARM_LAST);

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            hh           <= '0;
            mm           <= '0;
            ss           <= '0;
            day          <= 5'd1;
            month        <= 4'd1;
            alarm_hh     <= 5'd7;
            alarm_mm     <= '0;
            alarm_active <= 1'b0;
            alarmCnt     <= '0;
        end else begin
            hh       <= hhNext;
            mm       <= mmNext;
            ss       <= ssNext;
            day      <= dayNext;
            month    <= monthNext;
            alarm_hh <= aHhNext;
            alarm_mm <= aMmNext;
            if (alarmClr) begin
                alarm_active <= 1'b0;
                alarmCnt     <= '0;
            end else if (alarmHit) begin
                alarm_active <= 1'b1;
                alarmCnt     <= '0;
            end else if (alarm_active && sec_tick) begin
                alarmCnt <= alarmCnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: edits, rollover, alarm and hold.
// Three instances share stimulus: default, short alarm, separate reset.
module tb_time_keeper;

    logic       mclk = 1'b0;
    logic       rst = 1'b0;
    logic       rstR = 1'b0;
    logic [1:0] clk_mode = 2'd0;
    logic [1:0] vButton = 2'd0;

    always #5 mclk = ~mclk;

    int nCmp = 0;
    int nBad = 0;

    logic [4:0] hh, day, alarm_hh;
    logic [5:0] mm, ss, alarm_mm;
    logic [3:0] month;
    logic       sec_tick, alarm_active;

    logic [4:0] sHh, sDay, sAlarmHh;
    logic [5:0] sMm, sSs, sAlarmMm;
    logic [3:0] sMonth;
    logic       sTick, sAlarm;

    logic [4:0] rHh, rDay, rAlarmHh;
    logic [5:0] rMm, rSs, rAlarmMm;
    logic [3:0] rMonth;
    logic       rTick, rAlarm;

    time_keeper #(.MFREQ_KHZ(1), .ALARM_SECS(60)) dut (
        .mclk(mclk), .rst(rst), .clk_mode(clk_mode), .vButton(vButton),
        .hh(hh), .mm(mm), .ss(ss), .day(day), .month(month),
        .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .sec_tick(sec_tick), .alarm_active(alarm_active)
    );

    time_keeper #(.MFREQ_KHZ(1), .ALARM_SECS(4)) dutShort (
        .mclk(mclk), .rst(rst), .clk_mode(clk_mode), .vButton(vButton),
        .hh(sHh), .mm(sMm), .ss(sSs), .day(sDay), .month(sMonth),
        .alarm_hh(sAlarmHh), .alarm_mm(sAlarmMm),
        .sec_tick(sTick), .alarm_active(sAlarm)
    );

    time_keeper #(.MFREQ_KHZ(1), .ALARM_SECS(60)) dutRst (
        .mclk(mclk), .rst(rstR), .clk_mode(clk_mode), .vButton(vButton),
        .hh(rHh), .mm(rMm), .ss(rSs), .day(rDay), .month(rMonth),
        .alarm_hh(rAlarmHh), .alarm_mm(rAlarmMm),
        .sec_tick(rTick), .alarm_active(rAlarm)
    );

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            vButton = b;
            step();
            vButton = 2'b00;
        end
    endtask

    // Waits for the next sec_tick, then one more edge so the time update shows.
    task automatic waitTick();
        int n;
        n = 0;
        while (sec_tick !== 1'b1 && n < 1100) begin
            step();
            n++;
        end
        if (sec_tick !== 1'b1) begin
            nCmp++;
            nBad++;
            $display("FAIL tick_timeout: no sec_tick within %0d cycles, required one", n);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rstR = 1'b0;
        #12;
        nCmp++;
        if ({hh, mm, ss, day, month, alarm_hh, alarm_mm, sec_tick, alarm_active}
            !== {5'd0, 6'd0, 6'd0, 5'd1, 4'd1, 5'd7, 6'd0, 1'b0, 1'b0}) begin
            nBad++;
            $display("FAIL reset: got %0d:%0d:%0d d%0d m%0d al %0d:%0d t%b a%b, required 0:0:0 d1 m1 al 7:0 t0 a0",
                     hh, mm, ss, day, month, alarm_hh, alarm_mm, sec_tick, alarm_active);
        end
        @(posedge mclk);
        #1;
        rst = 1'b1;
        rstR = 1'b1;
    endtask

    task automatic test_set_alarm();
        clk_mode = 2'd3;
        pulse(2'b11, 1);
        nCmp++;
        if ({alarm_hh, alarm_mm} !== {5'd8, 6'd1}) begin
            nBad++;
            $display("FAIL alarm_both: got %0d:%0d, required 8:1", alarm_hh, alarm_mm);
        end
        pulse(2'b10, 16);
        pulse(2'b01, 59);
        nCmp++;
        if ({alarm_hh, alarm_mm} !== {5'd0, 6'd0}) begin
            nBad++;
            $display("FAIL alarm_wrap: got %0d:%0d, required 0:0", alarm_hh, alarm_mm);
        end
    endtask

    task automatic test_set_date();
        clk_mode = 2'd2;
        pulse(2'b01, 30);
        nCmp++;
        if ({day, month} !== {5'd31, 4'd1}) begin
            nBad++;
            $display("FAIL date_31jan: got d%0d m%0d, required d31 m1", day, month);
        end
        pulse(2'b10, 1);
        nCmp++;
        if ({day, month} !== {5'd28, 4'd2}) begin
            nBad++;
            $display("FAIL date_clamp: got d%0d m%0d, required d28 m2", day, month);
        end
        pulse(2'b01, 1);
        nCmp++;
        if ({day, month} !== {5'd1, 4'd2}) begin
            nBad++;
            $display("FAIL date_feb_wrap: got d%0d m%0d, required d1 m2", day, month);
        end
        pulse(2'b10, 10);
        nCmp++;
        if ({day, month} !== {5'd1, 4'd12}) begin
            nBad++;
            $display("FAIL date_dec: got d%0d m%0d, required d1 m12", day, month);
        end
        pulse(2'b01, 30);
        nCmp++;
        if ({day, month, ss} !== {5'd31, 4'd12, 6'd0}) begin
            nBad++;
            $display("FAIL date_31dec: got d%0d m%0d ss%0d, required d31 m12 ss0", day, month, ss);
        end
    endtask

    task automatic test_set_time();
        clk_mode = 2'd1;
        pulse(2'b10, 23);
        pulse(2'b01, 59);
        nCmp++;
        if ({hh, mm, ss} !== {5'd23, 6'd59, 6'd0}) begin
            nBad++;
            $display("FAIL time_set: got %0d:%0d:%0d, required 23:59:0", hh, mm, ss);
        end
        pulse(2'b01, 1);
        nCmp++;
        if ({hh, mm} !== {5'd23, 6'd0}) begin
            nBad++;
            $display("FAIL time_mm_wrap: got %0d:%0d, required 23:0", hh, mm);
        end
        pulse(2'b01, 59);
        nCmp++;
        if ({hh, mm, ss} !== {5'd23, 6'd59, 6'd0}) begin
            nBad++;
            $display("FAIL time_reset_59: got %0d:%0d:%0d, required 23:59:0", hh, mm, ss);
        end
    endtask

    task automatic measureFirstTick(input string name);
        int n;
        n = 0;
        clk_mode = 2'd0;
        do begin
            step();
            n++;
        end while (sec_tick !== 1'b1 && n < 1100);
        nCmp++;
        if (n != 1000) begin
            nBad++;
            $display("FAIL %s: first sec_tick after %0d cycles, required 1000", name, n);
        end
    endtask

    task automatic test_rollover();
        measureFirstTick("first_tick");
        step();
        nCmp++;
        if ({ss, sec_tick} !== {6'd1, 1'b0}) begin
            nBad++;
            $display("FAIL tick_single: got ss%0d tick%b, required ss1 tick0", ss, sec_tick);
        end
        for (int i = 0; i < 58; i++) waitTick();
        nCmp++;
        if ({hh, mm, ss, alarm_active} !== {5'd23, 6'd59, 6'd59, 1'b0}) begin
            nBad++;
            $display("FAIL pre_roll: got %0d:%0d:%0d a%b, required 23:59:59 a0",
                     hh, mm, ss, alarm_active);
        end
        waitTick();
        nCmp++;
        if ({hh, mm, ss, day, month} !== {5'd0, 6'd0, 6'd0, 5'd1, 4'd1}) begin
            nBad++;
            $display("FAIL rollover: got %0d:%0d:%0d d%0d m%0d, required 0:0:0 d1 m1",
                     hh, mm, ss, day, month);
        end
        nCmp++;
        if ({alarm_active, sAlarm, rAlarm} !== 3'b111) begin
            nBad++;
            $display("FAIL alarm_rise: got %b%b%b, required 111", alarm_active, sAlarm, rAlarm);
        end
    endtask

    task automatic test_alarm();
        bit leak;
        waitTick();
        waitTick();
        rstR = 1'b0;
        #1;
        nCmp++;
        if ({rHh, rMm, rSs, rDay, rMonth, rAlarmHh, rAlarmMm, rTick, rAlarm}
            !== {5'd0, 6'd0, 6'd0, 5'd1, 4'd1, 5'd7, 6'd0, 1'b0, 1'b0}) begin
            nBad++;
            $display("FAIL reset_mid_alarm: got %0d:%0d:%0d d%0d m%0d al %0d:%0d t%b a%b, required 0:0:0 d1 m1 al 7:0 t0 a0",
                     rHh, rMm, rSs, rDay, rMonth, rAlarmHh, rAlarmMm, rTick, rAlarm);
        end
        step();
        step();
        rstR = 1'b1;
        leak = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rTick !== 1'b0 || rAlarm !== 1'b0 || rSs !== 6'd0) leak = 1'b1;
        end
        nCmp++;
        if (leak) begin
            nBad++;
            $display("FAIL reset_leak: got tick/alarm/ss activity after release, required none");
        end
        waitTick();
        nCmp++;
        if (sAlarm !== 1'b1) begin
            nBad++;
            $display("FAIL short_tick3: got alarm %b, required 1", sAlarm);
        end
        waitTick();
        nCmp++;
        if ({sAlarm, alarm_active} !== 2'b01) begin
            nBad++;
            $display("FAIL short_timeout: got short%b main%b, required short0 main1",
                     sAlarm, alarm_active);
        end
    endtask

    task automatic test_dismiss();
        pulse(2'b01, 1);
        nCmp++;
        if ({alarm_active, hh, mm, ss, day, month, alarm_hh, alarm_mm}
            !== {1'b0, 5'd0, 6'd0, 6'd4, 5'd1, 4'd1, 5'd0, 6'd0}) begin
            nBad++;
            $display("FAIL dismiss: got a%b %0d:%0d:%0d d%0d m%0d al %0d:%0d, required a0 0:0:4 d1 m1 al 0:0",
                     alarm_active, hh, mm, ss, day, month, alarm_hh, alarm_mm);
        end
    endtask

    task automatic test_hold();
        bit bad;
        clk_mode = 2'd1;
        step();
        bad = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (sec_tick !== 1'b0 || ss !== 6'd0) bad = 1'b1;
        end
        nCmp++;
        if (bad) begin
            nBad++;
            $display("FAIL hold: got tick or nonzero ss in set-time mode, required none");
        end
        measureFirstTick("restart_tick");
    endtask

    initial begin
        test_reset();
        test_set_alarm();
        test_set_date();
        test_set_time();
        test_rollover();
        test_alarm();
        test_dismiss();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Downstream consumer of the button controller. Takes `clk_mode` and the one-cycle `vButton` pulses and keeps the clock and calendar state.
- State held: running time (hh:mm:ss), calendar date (day/month) and alarm time (hh:mm).
- Applies user adjustments per mode and raises an alarm indication.
- Outputs feed the display/segment-driver stage.

Parameters:
- MFREQ_KHZ, 1, main clock frequency in kHz; one second = MFREQ_KHZ*1000 mclk cycles.
- ALARM_SECS, 60, number of seconds `alarm_active` stays high when not dismissed.

Ports:
- mclk  in  1  main clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- clk_mode  in  2  0 run, 1 set time, 2 set date, 3 set alarm
- vButton  in  2  one-cycle pulses; [0] units/minor field, [1] tens/major field
- hh  out  5  hours 0..23
- mm  out  6  minutes 0..59
- ss  out  6  seconds 0..59
- day  out  5  day of month 1..28/30/31
- month  out  4  month 1..12
- alarm_hh  out  5  alarm hour 0..23
- alarm_mm  out  6  alarm minute 0..59
- sec_tick  out  1  one-cycle pulse once per second
- alarm_active  out  1  high while alarm sounding

Behaviour:
- Reset (rst=0, asynchronous): hh=mm=ss=0, day=1, month=1, alarm_hh=7, alarm_mm=0, sec_tick=0, alarm_active=0, prescaler=0.
- Prescaler (32-bit):
  - counts 0..MFREQ_KHZ*1000-1 and wraps to 0;
  - sec_tick=1 in the cycle after the terminal count is registered, exactly one cycle per period.
- Mode 1 (set time):
  - prescaler held at 0, sec_tick held 0, ss forced to 0.
  - vButton[0]: mm = (mm+1) mod 60, no carry into hh.
  - vButton[1]: hh = (hh+1) mod 24.
- Modes 0, 2, 3: time advances on sec_tick.
  - ss 59->0 carries into mm; mm 59->0 carries into hh; hh 23->0 carries into day.
  - Day carry: day == monthlen(month) -> day=1 and month+1; month 12->1.
  - monthlen: Feb=28 (no leap years); Apr/Jun/Sep/Nov=30; all other months 31.
- Mode 2 (set date):
  - Time still runs, but the hh->day carry is discarded so the date is stable while editing.
  - vButton[0]: day+1, wrapping to 1 after monthlen(month).
  - vButton[1]: month+1, wrapping 12->1.
  - If the new month is shorter than the current day, day is clamped to monthlen(new month) in the same update (e.g. 31 Jan -> 28 Feb).
- Mode 3 (set alarm):
  - vButton[0]: alarm_mm = (alarm_mm+1) mod 60.
  - vButton[1]: alarm_hh = (alarm_hh+1) mod 24.
- Simultaneous events:
  - Both vButton bits pulsing in the same cycle: both fields update.
  - A button pulse coinciding with a sec_tick carry (modes 2/3): both applied independently. Button edits target only the date/alarm fields; the tick targets only the time fields.
  - Mode 1 has no tick, so it has no such conflict.
- vButton in mode 0: no field change; only dismisses the alarm.
- Alarm:
  - Set on a sec_tick in mode 0 that moves the time to alarm_hh:alarm_mm:00.
  - Internal second counter starts at 0 and counts sec_ticks while active.
  - Cleared when ALARM_SECS sec_ticks have elapsed, on any vButton pulse, or when clk_mode != 0.
  - Clearing has priority over setting in the same cycle.
- Mode change: all registers hold their values. On leaving mode 1, the prescaler restarts from 0, so the first sec_tick comes one full period later.
- Reset asserted mid-operation (including mid-alarm or mid-edit): immediate return to reset values, with no pending pulse leaking after release.
- Arithmetic: all field increments compare against the limit before incrementing; no out-of-range value is ever registered.

Decomposition:
- Shared package clock_pkg:
  - MODE_RUN=0, MODE_SET_TIME=1, MODE_SET_DATE=2, MODE_SET_ALARM=3;
  - field widths;
  - monthlen function/table.
- Sub-module sec_prescaler: parameter MFREQ_KHZ; ports mclk, rst, hold, sec_tick. It also serves the future stopwatch/timer blocks.

Test Plan (MFREQ_KHZ=1):
- Release reset, run 1000 cycles in mode 0 -> single sec_tick pulse, ss=1; 60000 cycles -> mm=1, ss=0.
- Preload 23:59:59, 31 Dec (via button edits), run 1 s in mode 0 -> 00:00:00, day=1, month=1.
- Mode 2 with day=31, month=1; pulse vButton[1] -> month=2, day=28. Mode 1 with mm=59; pulse vButton[0] -> mm=0, hh unchanged.
- Alarm at 00:01, mode 0 from reset -> alarm_active rises with the sec_tick reaching 00:01:00. Falls after 60 sec_ticks; on a repeat run, falls one cycle after a vButton[0] pulse.
- Mode 3: pulse both vButton bits in the same cycle from 07:00 -> alarm 08:01. Assert rst low mid-alarm -> all outputs at reset values immediately.
- Mode 1 for 5000 cycles -> sec_tick never pulses and ss stays 0. Return to mode 0 -> first sec_tick exactly 1000 cycles later.
